// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
module ex_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [RADDR-1:0] id_rs1_i,
    input  logic [RADDR-1:0] id_rs2_i,
    input  logic [RADDR-1:0] id_rd_i,
    input  logic [3:0]       id_alu_sel_i,
    input  logic             id_src1_pc_i,
    input  logic             id_src2_imm_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             exmem_wr_i,
    input  logic [RADDR-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]  exmem_data_i,
    input  logic             memwb_wr_i,
    input  logic [RADDR-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]  memwb_data_i,
    output logic [XLEN-1:0]  src1_o,
    output logic [XLEN-1:0]  src2_o,
    output logic [3:0]       alu_sel_o,
    output logic             ex_valid_o,
    output logic [RADDR-1:0] ex_rd_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_read_o,
    output logic [XLEN-1:0]  ex_store_data_o,
    output logic             load_use_stall_o
);

    logic             valid_q,     valid_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic [XLEN-1:0]  rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic [RADDR-1:0] rs1_q,       rs1_d;
    logic [RADDR-1:0] rs2_q,       rs2_d;
    logic [RADDR-1:0] rd_q,        rd_d;
    logic [3:0]       alu_sel_q,   alu_sel_d;
    logic             src1_pc_q,   src1_pc_d;
    logic             src2_imm_q,  src2_imm_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q,  mem_read_d;

    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;
    logic             load_use;

    // Load-use hazard: a valid load in EX whose rd is read by the instruction in ID.
    always_comb begin
        load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid_i
                   && ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
    end

    // Next-state for the ID/EX register: flush > stall > load-use bubble > capture.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_sel_d   = alu_sel_q;
        src1_pc_d   = src1_pc_q;
        src2_imm_d  = src2_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (flush_i || (!stall_i && load_use)) begin
            // Bubbles clear every field so nothing stale reaches the ALU or forwarding compares.
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            alu_sel_d   = '0;
            src1_pc_d   = 1'b0;
            src2_imm_d  = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (!stall_i) begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            rs1_data_d  = id_rs1_data_i;
            rs2_data_d  = id_rs2_data_i;
            imm_d       = id_imm_i;
            rs1_d       = id_rs1_i;
            rs2_d       = id_rs2_i;
            rd_d        = id_rd_i;
            alu_sel_d   = id_alu_sel_i;
            src1_pc_d   = id_src1_pc_i;
            src2_imm_d  = id_src2_imm_i;
            reg_write_d = id_reg_write_i && id_valid_i;
            mem_read_d  = id_mem_read_i && id_valid_i;
        end
    end

    // ID/EX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_sel_q   <= '0;
            src1_pc_q   <= 1'b0;
            src2_imm_q  <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_sel_q   <= alu_sel_d;
            src1_pc_q   <= src1_pc_d;
            src2_imm_q  <= src2_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; x0 always reads the captured value.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_wr_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_q)) begin
            fwd_rs1 = exmem_data_i;
        end else if (memwb_wr_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_q)) begin
            fwd_rs1 = memwb_data_i;
        end
        fwd_rs2 = rs2_data_q;
        if (exmem_wr_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_q)) begin
            fwd_rs2 = exmem_data_i;
        end else if (memwb_wr_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_q)) begin
            fwd_rs2 = memwb_data_i;
        end
    end

    // Operand select and EX-stage outputs, driven straight into the ALU.
    always_comb begin
        src1_o           = src1_pc_q  ? pc_q  : fwd_rs1;
        src2_o           = src2_imm_q ? imm_q : fwd_rs2;
        ex_store_data_o  = fwd_rs2;
        alu_sel_o        = alu_sel_q;
        ex_valid_o       = valid_q;
        ex_rd_o          = rd_q;
        ex_reg_write_o   = reg_write_q && valid_q;
        ex_mem_read_o    = mem_read_q && valid_q;
        load_use_stall_o = load_use;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding, x0 guard, load-use, flush/stall, AUIPC, reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [3:0]  id_alu_sel_i;
    logic        id_src1_pc_i, id_src2_imm_i, id_reg_write_i, id_mem_read_i;
    logic        exmem_wr_i, memwb_wr_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic [31:0] src1_o, src2_o, ex_store_data_o;
    logic [3:0]  alu_sel_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, load_use_stall_o;
    logic [4:0]  ex_rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_alu_sel_i(id_alu_sel_i),
        .id_src1_pc_i(id_src1_pc_i), .id_src2_imm_i(id_src2_imm_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
        .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .src1_o(src1_o), .src2_o(src2_o), .alu_sel_o(alu_sel_o), .ex_valid_o(ex_valid_o),
        .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_store_data_o(ex_store_data_o), .load_use_stall_o(load_use_stall_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; id_valid_i = 0;
        id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
        id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_alu_sel_i = 0;
        id_src1_pc_i = 0; id_src2_imm_i = 0; id_reg_write_i = 0; id_mem_read_i = 0;
        exmem_wr_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
        memwb_wr_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
    endtask

    // Plain register-register instruction in ID.
    task automatic set_id_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2);
        id_valid_i = 1; id_pc_i = 32'h100; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = 32'h4; id_alu_sel_i = 4'h0;
        id_src1_pc_i = 0; id_src2_imm_i = 0; id_reg_write_i = 1; id_mem_read_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        n_tests++; if (src1_o !== 32'h0) begin n_fail++; $display("FAIL reset_src1 got %h exp %h", src1_o, 32'h0); end
        n_tests++; if (src2_o !== 32'h0) begin n_fail++; $display("FAIL reset_src2 got %h exp %h", src2_o, 32'h0); end
        n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ex_valid_o); end
        n_tests++; if (load_use_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_lus got %b exp 0", load_use_stall_o); end
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_capture();
        clear_inputs();
        set_id_add(5'd1, 5'd2, 5'd3, 32'h10, 32'h20);
        step();
        n_tests++; if (src1_o !== 32'h10) begin n_fail++; $display("FAIL cap_src1 got %h exp %h", src1_o, 32'h10); end
        n_tests++; if (src2_o !== 32'h20) begin n_fail++; $display("FAIL cap_src2 got %h exp %h", src2_o, 32'h20); end
        n_tests++; if (ex_rd_o !== 5'd3) begin n_fail++; $display("FAIL cap_rd got %0d exp 3", ex_rd_o); end
        n_tests++; if (ex_reg_write_o !== 1'b1) begin n_fail++; $display("FAIL cap_rw got %b exp 1", ex_reg_write_o); end
        // Control bits masked when ID is not valid.
        id_valid_i = 0; id_mem_read_i = 1;
        step();
        n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL inval_valid got %b exp 0", ex_valid_o); end
        n_tests++; if (ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL inval_rw got %b exp 0", ex_reg_write_o); end
        n_tests++; if (ex_mem_read_o !== 1'b0) begin n_fail++; $display("FAIL inval_mr got %b exp 0", ex_mem_read_o); end
    endtask

    task automatic test_double_hazard();
        clear_inputs();
        set_id_add(5'd5, 5'd6, 5'd9, 32'h55, 32'h66);
        step();
        id_valid_i = 0;
        exmem_wr_i = 1; exmem_rd_i = 5'd5; exmem_data_i = 32'h11;
        memwb_wr_i = 1; memwb_rd_i = 5'd5; memwb_data_i = 32'h22;
        #1;
        n_tests++; if (src1_o !== 32'h11) begin n_fail++; $display("FAIL fwd_exmem got %h exp %h", src1_o, 32'h11); end
        exmem_wr_i = 0;
        #1;
        n_tests++; if (src1_o !== 32'h22) begin n_fail++; $display("FAIL fwd_memwb got %h exp %h", src1_o, 32'h22); end
        memwb_wr_i = 0;
        #1;
        n_tests++; if (src1_o !== 32'h55) begin n_fail++; $display("FAIL fwd_none got %h exp %h", src1_o, 32'h55); end
        memwb_wr_i = 1; memwb_rd_i = 5'd6; memwb_data_i = 32'h77;
        #1;
        n_tests++; if (src2_o !== 32'h77) begin n_fail++; $display("FAIL fwd_rs2 got %h exp %h", src2_o, 32'h77); end
        n_tests++; if (ex_store_data_o !== 32'h77) begin n_fail++; $display("FAIL fwd_store got %h exp %h", ex_store_data_o, 32'h77); end
        n_tests++; if (src1_o !== 32'h55) begin n_fail++; $display("FAIL fwd_rs1_untouched got %h exp %h", src1_o, 32'h55); end
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        set_id_add(5'd1, 5'd0, 5'd4, 32'h10, 32'h0);
        step();
        id_valid_i = 0;
        exmem_wr_i = 1; exmem_rd_i = 5'd0; exmem_data_i = 32'hDEAD;
        memwb_wr_i = 1; memwb_rd_i = 5'd0; memwb_data_i = 32'hBEEF;
        #1;
        n_tests++; if (src2_o !== 32'h0) begin n_fail++; $display("FAIL x0_src2 got %h exp %h", src2_o, 32'h0); end
        n_tests++; if (ex_store_data_o !== 32'h0) begin n_fail++; $display("FAIL x0_store got %h exp %h", ex_store_data_o, 32'h0); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        // lw x7, 0(x1)
        set_id_add(5'd1, 5'd0, 5'd7, 32'h40, 32'h0);
        id_mem_read_i = 1;
        step();
        n_tests++; if (ex_mem_read_o !== 1'b1) begin n_fail++; $display("FAIL lu_load_mr got %b exp 1", ex_mem_read_o); end
        // add x8, x2, x7
        set_id_add(5'd2, 5'd7, 5'd8, 32'h3, 32'h9);
        #1;
        n_tests++; if (load_use_stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_assert got %b exp 1", load_use_stall_o); end
        step();
        n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", ex_valid_o); end
        n_tests++; if (load_use_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle got %b exp 0", load_use_stall_o); end
        step();
        n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL lu_add_valid got %b exp 1", ex_valid_o); end
        n_tests++; if (ex_rd_o !== 5'd8) begin n_fail++; $display("FAIL lu_add_rd got %0d exp 8", ex_rd_o); end
        n_tests++; if (load_use_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_after got %b exp 0", load_use_stall_o); end
    endtask

    task automatic test_flush_stall();
        clear_inputs();
        set_id_add(5'd1, 5'd2, 5'd9, 32'h1, 32'h2);
        step();
        flush_i = 1; stall_i = 1;
        step();
        n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", ex_valid_o); end
        n_tests++; if (ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL flush_rw got %b exp 0", ex_reg_write_o); end
        flush_i = 0; stall_i = 0;
        set_id_add(5'd1, 5'd2, 5'd10, 32'h1, 32'h2);
        id_alu_sel_i = 4'h3;
        step();
        stall_i = 1;
        set_id_add(5'd3, 5'd4, 5'd11, 32'h5, 32'h6);
        id_alu_sel_i = 4'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (ex_rd_o !== 5'd10) begin n_fail++; $display("FAIL stall_rd[%0d] got %0d exp 10", i, ex_rd_o); end
            n_tests++; if (alu_sel_o !== 4'h3) begin n_fail++; $display("FAIL stall_alu[%0d] got %h exp 3", i, alu_sel_o); end
            n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, ex_valid_o); end
        end
        stall_i = 0;
        step();
        n_tests++; if (ex_rd_o !== 5'd11) begin n_fail++; $display("FAIL unstall_rd got %0d exp 11", ex_rd_o); end
    endtask

    task automatic test_auipc();
        clear_inputs();
        set_id_add(5'd0, 5'd4, 5'd12, 32'h77, 32'h88);
        id_pc_i = 32'h1000; id_imm_i = 32'h2000; id_src1_pc_i = 1; id_src2_imm_i = 1; id_alu_sel_i = 4'hA;
        step();
        n_tests++; if (src1_o !== 32'h1000) begin n_fail++; $display("FAIL auipc_src1 got %h exp %h", src1_o, 32'h1000); end
        n_tests++; if (src2_o !== 32'h2000) begin n_fail++; $display("FAIL auipc_src2 got %h exp %h", src2_o, 32'h2000); end
        n_tests++; if (alu_sel_o !== 4'hA) begin n_fail++; $display("FAIL auipc_alu got %h exp a", alu_sel_o); end
        n_tests++; if (ex_store_data_o !== 32'h88) begin n_fail++; $display("FAIL auipc_store got %h exp %h", ex_store_data_o, 32'h88); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_id_add(5'd1, 5'd2, 5'd3, 32'h10, 32'h20);
        step();
        n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b exp 1", ex_valid_o); end
        #1 rst_n = 0;
        id_rd_i = 5'd12;
        #1;
        n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", ex_valid_o); end
        n_tests++; if (src1_o !== 32'h0) begin n_fail++; $display("FAIL rmid_src1 got %h exp %h", src1_o, 32'h0); end
        n_tests++; if (ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rw got %b exp 0", ex_reg_write_o); end
        n_tests++; if (ex_rd_o !== 5'd0) begin n_fail++; $display("FAIL rmid_rd got %0d exp 0", ex_rd_o); end
        #1 rst_n = 1;
        step();
        n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_post_valid got %b exp 1", ex_valid_o); end
        n_tests++; if (ex_rd_o !== 5'd12) begin n_fail++; $display("FAIL rmid_post_rd got %0d exp 12", ex_rd_o); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_double_hazard();
        test_x0_guard();
        test_load_use();
        test_flush_stall();
        test_auipc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
